calc_prog_sender: RTL and testbench

Transmit-side companion for the lab-4 opcode-cache calculator: it accepts instruction words from a host over a valid/ready port, buffers them in a small FIFO, and drives the calculator's `mode`/`opCode`/`value` inputs so every issued instruction lands in the calculator's 32-entry cache exactly once. On host command it switches the calculator into execute mode for a programmed number of clocks, then returns to load mode. It sits between the host/testbench stimulus and the calculator.

---
 rtl/calc_prog_sender.sv | 192 +++++++++++++++++++
 tb/tb_calc_prog_sender.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_prog_sender.sv
// calc_prog_sender: buffers host instructions and feeds them to the opcode-cache
// calculator one per clock, then runs the calculator in execute mode on request.
module calc_prog_sender #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CACHE_DEPTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_op,
  input  logic [3:0] in_value,
  input  logic       run_start,
  input  logic [7:0] run_count,
  output logic       mode,
  output logic [2:0] opCode,
  output logic [3:0] value,
  output logic       reject,
  output logic       run_err,
  output logic       done,
  output logic       busy,
  output logic       cache_full
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SENT_W = $clog2(CACHE_DEPTH + 1);

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] val;
  } instr_t;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_n;
  instr_t            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [SENT_W-1:0] r_sent;
  logic [7:0]        r_run_cnt;
  logic              r_done_pend;

  logic              r_in_ready;
  logic              r_mode;
  logic [2:0]        r_op;
  logic [3:0]        r_val;
  logic              r_reject;
  logic              r_run_err;
  logic              r_done;
  logic              r_busy;
  logic              r_cache_full;

  logic              w_push;
  logic              w_legal;
  logic              w_enq;
  logic              w_pop;
  logic              w_full_now;
  logic [CNT_W-1:0]  w_count_n;
  logic [SENT_W-1:0] w_sent_n;
  logic [7:0]        w_run_cnt_n;
  logic              w_done_pend_n;
  logic              w_mode_n;
  logic [2:0]        w_op_n;
  logic [3:0]        w_val_n;
  logic              w_run_err_n;
  logic              w_done_n;
  logic              w_busy_n;

  assign in_ready   = r_in_ready;
  assign mode       = r_mode;
  assign opCode     = r_op;
  assign value      = r_val;
  assign reject     = r_reject;
  assign run_err    = r_run_err;
  assign done       = r_done;
  assign busy       = r_busy;
  assign cache_full = r_cache_full;

  // Host handshake classification and occupancy/issue bookkeeping
  always_comb begin
    w_push     = in_valid && r_in_ready;
    w_legal    = (in_op[1:0] != 2'b11);
    w_enq      = w_push && w_legal;
    w_full_now = (r_sent == SENT_W'(CACHE_DEPTH));
    w_count_n  = r_count + CNT_W'(w_enq) - CNT_W'(w_pop);
    w_sent_n   = r_sent + SENT_W'(w_pop);
  end

  // Next-state and next-output decode; idle filler unless something is issued
  always_comb begin
    w_state_n     = r_state;
    w_run_cnt_n   = r_run_cnt;
    w_done_pend_n = 1'b0;
    w_pop         = 1'b0;
    w_mode_n      = 1'b0;
    w_op_n        = 3'b111;
    w_val_n       = 4'd0;
    w_run_err_n   = 1'b0;
    w_done_n      = r_done_pend;
    w_busy_n      = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_pop = (r_count != '0) && !w_full_now;
        if (w_pop) begin
          w_op_n  = r_mem[r_rd_ptr].op;
          w_val_n = r_mem[r_rd_ptr].val;
        end
        if (run_start) begin
          if ((r_count == '0) && (r_sent != '0) && (run_count != 8'd0)) begin
            w_state_n   = ST_RUN;
            w_run_cnt_n = run_count;
          end else begin
            w_run_err_n = 1'b1;
          end
        end
      end
      ST_RUN: begin
        w_mode_n    = 1'b1;
        w_busy_n    = 1'b1;
        w_run_err_n = run_start;
        w_run_cnt_n = r_run_cnt - 8'd1;
        if (r_run_cnt == 8'd1) begin
          w_state_n     = ST_LOAD;
          w_done_pend_n = 1'b1;
        end
      end
      default: begin
        w_state_n = ST_LOAD;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Counters, pointers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_sent       <= '0;
      r_run_cnt    <= 8'd0;
      r_done_pend  <= 1'b0;
      r_in_ready   <= 1'b1;
      r_mode       <= 1'b0;
      r_op         <= 3'b111;
      r_val        <= 4'd0;
      r_reject     <= 1'b0;
      r_run_err    <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_cache_full <= 1'b0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count      <= w_count_n;
      r_sent       <= w_sent_n;
      r_run_cnt    <= w_run_cnt_n;
      r_done_pend  <= w_done_pend_n;
      r_in_ready   <= (w_count_n != CNT_W'(FIFO_DEPTH));
      r_mode       <= w_mode_n;
      r_op         <= w_op_n;
      r_val        <= w_val_n;
      r_reject     <= w_push && !w_legal;
      r_run_err    <= w_run_err_n;
      r_done       <= w_done_n;
      r_busy       <= w_busy_n;
      r_cache_full <= (w_sent_n == SENT_W'(CACHE_DEPTH));
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= instr_t'({in_op, in_value});
    end
  end

endmodule

// File: tb/tb_calc_prog_sender.sv
// Self-checking bench for calc_prog_sender: a queue-based reference model predicts
// every output each cycle; scenario tasks add targeted checks.
module tb_calc_prog_sender;

  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned CACHE_DEPTH = 32;
  localparam logic [13:0] RESET_VEC   = 14'b0_111_0000_1_00000;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [3:0] in_value;
  logic       run_start;
  logic [7:0] run_count;
  logic       mode;
  logic [2:0] opCode;
  logic [3:0] value;
  logic       reject;
  logic       run_err;
  logic       done;
  logic       busy;
  logic       cache_full;

  calc_prog_sender #(.FIFO_DEPTH(FIFO_DEPTH), .CACHE_DEPTH(CACHE_DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_value(in_value), .run_start(run_start), .run_count(run_count),
    .mode(mode), .opCode(opCode), .value(value), .reject(reject), .run_err(run_err),
    .done(done), .busy(busy), .cache_full(cache_full)
  );

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] val;
  } ins_t;

  // Reference model state
  ins_t        m_q[$];
  int          m_sent;
  int          m_run_left;
  bit          m_in_run;
  bit          m_done_due;
  logic [13:0] exp_vec;

  int n_checks;
  int n_pass;

  always #5 clk = ~clk;

  function automatic logic [13:0] dut_vec();
    return {mode, opCode, value, in_ready, reject, run_err, done, busy, cache_full};
  endfunction

  function automatic logic [2:0] rand_legal_op();
    int idx;
    idx = int'($urandom_range(0, 5));
    return (idx < 3) ? 3'(idx) : 3'(idx + 1);
  endfunction

  // Behavioural model: what the outputs must show after each clock edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_sent     = 0;
      m_run_left = 0;
      m_in_run   = 0;
      m_done_due = 0;
      exp_vec    = RESET_VEC;
    end else begin
      bit hs, legal, e_mode, e_rej, e_err, e_done, e_busy;
      logic [2:0] e_op;
      logic [3:0] e_val;
      ins_t nw;
      hs     = in_valid && (m_q.size() < int'(FIFO_DEPTH));
      legal  = (in_op != 3'd3) && (in_op != 3'd7);
      e_mode = 0; e_op = 3'b111; e_val = 4'd0; e_err = 0; e_done = 0; e_busy = 0;
      e_rej  = hs && !legal;
      if (m_in_run) begin
        e_mode = 1;
        e_busy = 1;
        e_err  = run_start;
        m_run_left--;
        if (m_run_left == 0) begin
          m_in_run   = 0;
          m_done_due = 1;
        end
      end else begin
        e_done     = m_done_due;
        m_done_due = 0;
        if (run_start) begin
          if (m_q.size() == 0 && m_sent > 0 && run_count != 0) begin
            m_in_run   = 1;
            m_run_left = int'(run_count);
          end else begin
            e_err = 1;
          end
        end
        if (m_q.size() > 0 && m_sent < int'(CACHE_DEPTH)) begin
          e_op  = m_q[0].op;
          e_val = m_q[0].val;
          void'(m_q.pop_front());
          m_sent++;
        end
      end
      if (hs && legal) begin
        nw.op  = in_op;
        nw.val = in_value;
        m_q.push_back(nw);
      end
      exp_vec = {e_mode, e_op, e_val, (m_q.size() < int'(FIFO_DEPTH)), e_rej, e_err,
                 e_done, e_busy, (m_sent == int'(CACHE_DEPTH))};
    end
  end

  task automatic drive_idle();
    in_valid  = 0;
    in_op     = 3'd0;
    in_value  = 4'd0;
    run_start = 0;
    run_count = 8'd0;
  endtask

  task automatic test_reset();
    reset = 1;
    drive_idle();
    repeat (2) @(negedge clk);
    n_checks++;
    if (dut_vec() !== RESET_VEC)
      $display("FAIL reset_values got=%b want=%b", dut_vec(), RESET_VEC);
    else n_pass++;
    reset = 0;
    @(negedge clk);
    n_checks++;
    if (dut_vec() !== exp_vec)
      $display("FAIL after_reset got=%b want=%b", dut_vec(), exp_vec);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [2:0] ops [3];
    logic [3:0] vals[3];
    ops[0] = 3'd0; vals[0] = 4'd5;
    ops[1] = 3'd1; vals[1] = 4'd3;
    ops[2] = 3'd4; vals[2] = 4'd0;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) begin
        in_valid = 1; in_op = ops[i]; in_value = vals[i];
      end else begin
        drive_idle();
      end
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_vec)
        $display("FAIL basic[%0d] got=%b want=%b", i, dut_vec(), exp_vec);
      else n_pass++;
      if (i >= 1 && i <= 3) begin
        n_checks++;
        if ({mode, opCode, value} !== {1'b0, ops[i-1], vals[i-1]})
          $display("FAIL basic_issue[%0d] got=%b_%0d_%0d want=0_%0d_%0d",
                   i, mode, opCode, value, ops[i-1], vals[i-1]);
        else n_pass++;
      end
    end
    n_checks++;
    if (opCode !== 3'b111)
      $display("FAIL basic_filler got=%0d want=7", opCode);
    else n_pass++;
  endtask

  task automatic test_reject();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin in_valid = 1; in_op = 3'd3; in_value = 4'($urandom); end
      else if (i == 1) begin in_valid = 1; in_op = 3'd7; in_value = 4'($urandom); end
      else drive_idle();
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_vec)
        $display("FAIL reject[%0d] got=%b want=%b", i, dut_vec(), exp_vec);
      else n_pass++;
      if (i < 2) begin
        n_checks++;
        if (reject !== 1'b1 || opCode !== 3'b111)
          $display("FAIL reject_pulse[%0d] got=%b/%0d want=1/7", i, reject, opCode);
        else n_pass++;
      end
    end
  endtask

  task automatic test_run();
    int mode_cycles;
    int done_cnt;
    mode_cycles = 0;
    done_cnt    = 0;
    run_start = 1; run_count = 8'd5;
    @(negedge clk);
    drive_idle();
    n_checks++;
    if (dut_vec() !== exp_vec)
      $display("FAIL run_accept got=%b want=%b", dut_vec(), exp_vec);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_vec)
        $display("FAIL run[%0d] got=%b want=%b", i, dut_vec(), exp_vec);
      else n_pass++;
      if (mode) mode_cycles++;
      if (done) done_cnt++;
    end
    n_checks++;
    if (mode_cycles != 5 || done_cnt != 1)
      $display("FAIL run_length got=%0d/%0d want=5/1", mode_cycles, done_cnt);
    else n_pass++;
    run_start = 1; run_count = 8'd0;
    @(negedge clk);
    drive_idle();
    n_checks++;
    if (run_err !== 1'b1 || dut_vec() !== exp_vec)
      $display("FAIL run_zero got=%b want=%b", dut_vec(), exp_vec);
    else n_pass++;
    in_valid = 1; in_op = rand_legal_op(); in_value = 4'($urandom);
    @(negedge clk);
    drive_idle();
    run_start = 1; run_count = 8'd4;
    @(negedge clk);
    drive_idle();
    n_checks++;
    if (run_err !== 1'b1 || dut_vec() !== exp_vec)
      $display("FAIL run_nonempty got=%b want=%b", dut_vec(), exp_vec);
    else n_pass++;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || dut_vec() !== exp_vec)
        $display("FAIL run_refused_idle got=%b want=%b", dut_vec(), exp_vec);
      else n_pass++;
    end
  endtask

  task automatic test_run_fill();
    bit seen_not_ready;
    seen_not_ready = 0;
    run_start = 1; run_count = 8'd20;
    @(negedge clk);
    drive_idle();
    for (int i = 0; i < 40; i++) begin
      if (i < 12) begin
        in_valid = 1; in_op = rand_legal_op(); in_value = 4'($urandom);
      end else begin
        drive_idle();
      end
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_vec)
        $display("FAIL run_fill[%0d] got=%b want=%b", i, dut_vec(), exp_vec);
      else n_pass++;
      if (!in_ready) seen_not_ready = 1;
    end
    n_checks++;
    if (!seen_not_ready)
      $display("FAIL run_fill_ready got=no_backpressure want=in_ready_low");
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      in_valid  = 1'($urandom);
      in_op     = 3'($urandom);
      in_value  = 4'($urandom);
      run_start = ($urandom_range(0, 11) == 0);
      run_count = 8'($urandom_range(0, 6));
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_vec)
        $display("FAIL random[%0d] got=%b want=%b", i, dut_vec(), exp_vec);
      else n_pass++;
    end
    drive_idle();
  endtask

  task automatic test_cache_full();
    int issued;
    issued = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 34) begin
        in_valid = 1; in_op = rand_legal_op(); in_value = 4'($urandom);
      end else begin
        drive_idle();
      end
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_vec)
        $display("FAIL cache_fill[%0d] got=%b want=%b", i, dut_vec(), exp_vec);
      else n_pass++;
      if (opCode != 3'b111) issued++;
      if (i == 32) begin
        n_checks++;
        if (cache_full !== 1'b1)
          $display("FAIL cache_full_rise got=%b want=1", cache_full);
        else n_pass++;
      end
    end
    n_checks++;
    if (issued != 32 || in_ready !== 1'b1 || cache_full !== 1'b1)
      $display("FAIL cache_limit got=%0d/%b/%b want=32/1/1", issued, in_ready, cache_full);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int done_cnt;
    done_cnt = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    in_valid = 1; in_op = rand_legal_op(); in_value = 4'($urandom);
    @(negedge clk);
    drive_idle();
    repeat (2) @(negedge clk);
    run_start = 1; run_count = 8'd10;
    @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || mode !== 1'b1)
      $display("FAIL mid_run_active got=%b/%b want=1/1", busy, mode);
    else n_pass++;
    #2 reset = 1;
    #1;
    n_checks++;
    if (dut_vec() !== RESET_VEC)
      $display("FAIL async_reset got=%b want=%b", dut_vec(), RESET_VEC);
    else n_pass++;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_vec)
        $display("FAIL post_reset[%0d] got=%b want=%b", i, dut_vec(), exp_vec);
      else n_pass++;
      if (done) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 0)
      $display("FAIL no_done_after_reset got=%0d want=0", done_cnt);
    else n_pass++;
    run_start = 1; run_count = 8'd3;
    @(negedge clk);
    drive_idle();
    n_checks++;
    if (run_err !== 1'b1 || dut_vec() !== exp_vec)
      $display("FAIL sent_cleared got=%b want=%b", dut_vec(), exp_vec);
    else n_pass++;
  endtask

  initial begin
    clk      = 0;
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_reject();
    test_run();
    test_run_fill();
    test_random();
    test_cache_full();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
